// File: rtl/icache_pkg.sv
// Shared types and default widths for the direct-mapped instruction cache.
// Every cache line holds one little-endian word refilled one byte per cycle.
package icache_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_INST_WIDTH = 32;
    localparam int DEF_INDEX_BITS = 6;
    localparam int REFILL_BEATS   = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REFILL  = 2'd1,
        RESPOND = 2'd2
    } state_e;

endpackage

// File: rtl/inst_cache_if.sv
// Fetch and memory side of the instruction cache.
// The slave modport belongs to the cache; the master to fetcher and memory.
interface inst_cache_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
);
    logic                  inst_read_valid;
    logic [ADDR_WIDTH-1:0] inst_read_addr;
    logic                  inst_read_done;
    logic [INST_WIDTH-1:0] inst_read_data;
    logic [ADDR_WIDTH-1:0] mem_a;
    logic [7:0]            mem_din;

    modport slave (
        input  inst_read_valid, inst_read_addr, mem_din,
        output inst_read_done, inst_read_data, mem_a
    );

    modport master (
        output inst_read_valid, inst_read_addr, mem_din,
        input  inst_read_done, inst_read_data, mem_a
    );
endinterface

// File: rtl/icache_line_store.sv
// Tag/data/valid storage: one combinational read port, one write port.
// Only the valid bits are reset; clr_all_i wipes them in one cycle.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int TAG_W      = 24,
    parameter int DATA_W     = DEF_INST_WIDTH,
    parameter int INDEX_BITS = DEF_INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_all_i,
    input  logic                  we_i,
    input  logic [INDEX_BITS-1:0] wr_idx_i,
    input  logic [TAG_W-1:0]      wr_tag_i,
    input  logic [DATA_W-1:0]     wr_data_i,
    input  logic [INDEX_BITS-1:0] rd_idx_i,
    output logic                  rd_valid_o,
    output logic [TAG_W-1:0]      rd_tag_o,
    output logic [DATA_W-1:0]     rd_data_o
);
    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
        end else if (clr_all_i) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (we_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_data_o  = data_q[rd_idx_i];
endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache with a byte-wide refill port.
// Hit answers next cycle; a miss fetches four bytes and answers at T+6.
module inst_cache
    import icache_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int INST_WIDTH = DEF_INST_WIDTH,
    parameter int INDEX_BITS = DEF_INDEX_BITS
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rdy,
    input  logic           inst_cache_flush,
    inst_cache_if.slave    bus
);
    localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
    logic [INST_WIDTH-1:0] data_q, data_d;
    logic [23:0]           buf_q, buf_d;
    logic [2:0]            cnt_q, cnt_d;

    logic                  we, clr_all, hit;
    logic                  rd_valid;
    logic [TAG_W-1:0]      rd_tag;
    logic [INST_WIDTH-1:0] rd_data;
    logic [31:0]           word;
    logic                  unused_addr_lsbs;

    wire [INDEX_BITS-1:0] req_idx = bus.inst_read_addr[INDEX_BITS+1:2];
    wire [TAG_W-1:0]      req_tag = bus.inst_read_addr[ADDR_WIDTH-1:INDEX_BITS+2];
    wire [ADDR_WIDTH-1:0] line_addr = {bus.inst_read_addr[ADDR_WIDTH-1:2], 2'b00};

    assign unused_addr_lsbs = ^bus.inst_read_addr[1:0];
    assign hit  = rd_valid && (rd_tag == req_tag);
    assign word = {bus.mem_din, buf_q};

    icache_line_store #(
        .TAG_W      (TAG_W),
        .DATA_W     (INST_WIDTH),
        .INDEX_BITS (INDEX_BITS)
    ) u_store (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_all_i  (clr_all),
        .we_i       (we),
        .wr_idx_i   (mem_a_q[INDEX_BITS+1:2]),
        .wr_tag_i   (mem_a_q[ADDR_WIDTH-1:INDEX_BITS+2]),
        .wr_data_i  (INST_WIDTH'(word)),
        .rd_idx_i   (req_idx),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_data_o  (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mem_a_q <= '0;
            data_q  <= '0;
            buf_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            mem_a_q <= mem_a_d;
            data_q  <= data_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mem_a_d = mem_a_q;
        data_d  = data_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        we      = 1'b0;
        clr_all = 1'b0;
        if (rdy) begin
            unique case (state_q)
                IDLE: begin
                    if (inst_cache_flush) begin
                        clr_all = 1'b1;
                    end else if (bus.inst_read_valid) begin
                        if (hit) begin
                            state_d = RESPOND;
                            data_d  = rd_data;
                        end else begin
                            state_d = REFILL;
                            mem_a_d = line_addr;
                            cnt_d   = '0;
                        end
                    end
                end
                REFILL: begin
                    if (inst_cache_flush) begin
                        clr_all = 1'b1;
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        // mem_din lags mem_a by one cycle, so beat n holds byte n-1
                        case (cnt_q)
                            3'd1:    buf_d[7:0]   = bus.mem_din;
                            3'd2:    buf_d[15:8]  = bus.mem_din;
                            3'd3:    buf_d[23:16] = bus.mem_din;
                            default: ;
                        endcase
                        if (cnt_q == 3'(REFILL_BEATS)) begin
                            we      = 1'b1;
                            data_d  = INST_WIDTH'(word);
                            state_d = RESPOND;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                            if (cnt_q < 3'(REFILL_BEATS - 1))
                                mem_a_d = mem_a_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                RESPOND: begin
                    state_d = IDLE;
                    clr_all = inst_cache_flush;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.inst_read_done = (state_q == RESPOND);
    assign bus.inst_read_data = data_q;
    assign bus.mem_a          = mem_a_q;
endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: hits, misses, conflicts, flush, stall, reset.
// A byte-wide memory answers one cycle after mem_a and holds while rdy is low.
module tb_inst_cache;
    import icache_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rdy = 1'b1;
    logic inst_cache_flush = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    inst_cache_if #(.ADDR_WIDTH(32), .INST_WIDTH(32)) bus ();

    inst_cache dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rdy              (rdy),
        .inst_cache_flush (inst_cache_flush),
        .bus              (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h1000: return 8'h13;
            32'h1001: return 8'h00;
            32'h1002: return 8'h00;
            32'h1003: return 8'h00;
            32'h1100: return 8'h93;
            32'h1101: return 8'h00;
            32'h1102: return 8'h10;
            32'h1103: return 8'h00;
            32'h2000: return 8'h37;
            32'h2001: return 8'h12;
            32'h2002: return 8'h00;
            32'h2003: return 8'h00;
            default:  return a[7:0] ^ 8'hA5;
        endcase
    endfunction

    always @(posedge clk)
        if (rdy) bus.mem_din <= mem_byte(bus.mem_a);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // flush_at: -1 none, 0 with the request; rdylo_at/rst_at: 0 none
    task automatic fetch(input string tag, input logic [31:0] addr,
                         input int flush_at, input int rdylo_at, input int rdylo_len,
                         input int rst_at, input int exp_lat, input logic [31:0] exp_data,
                         input bit chk_mema);
        int lat;
        int pulses;
        logic [31:0] pre_a;
        logic [31:0] ma [0:15];
        lat = 0;
        pulses = 0;
        @(negedge clk);
        pre_a = bus.mem_a;
        bus.inst_read_valid = 1'b1;
        bus.inst_read_addr  = addr;
        inst_cache_flush    = (flush_at == 0);
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            bus.inst_read_valid = 1'b0;
            ma[n] = bus.mem_a;
            if (bus.inst_read_done === 1'b1) begin
                pulses++;
                if (lat == 0) lat = n;
            end
            if (flush_at > 0 && n == flush_at + 1 && exp_lat == 0)
                chk({tag, " state after flush"}, 64'(dut.state_q), 64'(IDLE));
            inst_cache_flush = (n == flush_at);
            if (rdylo_at > 0)
                rdy = !(n >= rdylo_at && n < rdylo_at + rdylo_len);
            if (rst_at > 0 && n == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk({tag, " rst done"}, 64'(bus.inst_read_done), 64'(0));
                chk({tag, " rst data"}, 64'(bus.inst_read_data), 64'(0));
                chk({tag, " rst mem_a"}, 64'(bus.mem_a), 64'(0));
            end
            if (rst_at > 0 && n == rst_at + 1) rst_n = 1'b1;
        end
        inst_cache_flush = 1'b0;
        rdy = 1'b1;
        chk({tag, " pulses"}, 64'(pulses), 64'(exp_lat > 0 ? 1 : 0));
        if (exp_lat > 0) begin
            chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
            chk({tag, " data held"}, 64'(bus.inst_read_data), 64'(exp_data));
        end
        if (chk_mema) begin
            for (int k = 0; k < 4; k++)
                chk({tag, " mem_a"}, 64'(ma[k+1]), 64'({addr[31:2], 2'b00} + k));
        end
        if (exp_lat == 1)
            chk({tag, " mem_a kept"}, 64'(ma[1]), 64'(pre_a));
    endtask

    initial begin
        bus.inst_read_valid = 1'b0;
        bus.inst_read_addr  = '0;
        repeat (2) @(negedge clk);
        chk("reset done", 64'(bus.inst_read_done), 64'(0));
        chk("reset data", 64'(bus.inst_read_data), 64'(0));
        chk("reset mem_a", 64'(bus.mem_a), 64'(0));
        chk("reset state", 64'(dut.state_q), 64'(IDLE));
        rst_n = 1'b1;

        fetch("cold miss",    32'h1000, -1, 0, 0, 0, 6, 32'h0000_0013, 1'b1);
        fetch("hit",          32'h1000, -1, 0, 0, 0, 1, 32'h0000_0013, 1'b0);
        fetch("hit lsb",      32'h1002, -1, 0, 0, 0, 1, 32'h0000_0013, 1'b0);
        fetch("conflict",     32'h1100, -1, 0, 0, 0, 6, 32'h0010_0093, 1'b1);
        fetch("evicted",      32'h1000, -1, 0, 0, 0, 6, 32'h0000_0013, 1'b1);
        fetch("refill flush", 32'h2000,  3, 0, 0, 0, 0, 32'h0,         1'b0);
        fetch("post flush",   32'h1000, -1, 0, 0, 0, 6, 32'h0000_0013, 1'b1);
        fetch("respond flush",32'h1000,  1, 0, 0, 0, 1, 32'h0000_0013, 1'b0);
        fetch("after rflush", 32'h1000, -1, 0, 0, 0, 6, 32'h0000_0013, 1'b1);
        fetch("rdy stall",    32'h2000, -1, 2, 3, 0, 9, 32'h0000_1237, 1'b0);
        fetch("stall hit",    32'h2000, -1, 0, 0, 0, 1, 32'h0000_1237, 1'b0);
        fetch("idle flush",   32'h2000,  0, 0, 0, 0, 0, 32'h0,         1'b0);
        fetch("after iflush", 32'h2000, -1, 0, 0, 0, 6, 32'h0000_1237, 1'b1);
        fetch("reset refill", 32'h3000, -1, 0, 0, 2, 0, 32'h0,         1'b0);
        fetch("after reset",  32'h3000, -1, 0, 0, 0, 6, 32'hA6A7_A4A5, 1'b1);
        fetch("reset cleared",32'h2000, -1, 0, 0, 0, 6, 32'h0000_1237, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/inst_cache.md
INST_CACHE -- requirements
Module: inst_cache

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte address width.
REQ-002 SHALL have parameter INST_WIDTH, default 32, instruction/line width.
REQ-003 SHALL have parameter INDEX_BITS, default 6, giving 2^INDEX_BITS direct-mapped one-word lines.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port rdy, input, 1, global enable; low freezes all state and outputs.
REQ-007 SHALL have port inst_read_valid, input, 1, fetch request from the instruction fetcher.
REQ-008 SHALL have port inst_read_addr, input, ADDR_WIDTH, fetch byte address.
REQ-009 SHALL have port inst_read_done, output, 1, one-cycle pulse: data valid.
REQ-010 SHALL have port inst_read_data, output, INST_WIDTH, fetched instruction.
REQ-011 SHALL have port inst_cache_flush, input, 1, invalidate all lines / abort refill.
REQ-012 SHALL have port mem_a, output, ADDR_WIDTH, byte address to memory.
REQ-013 SHALL have port mem_din, input, 8, byte returned by memory one cycle after mem_a.

Function
REQ-014 SHALL implement states IDLE, REFILL, RESPOND; requests SHALL be accepted only in IDLE with rdy=1.
REQ-015 SHALL ignore inst_read_addr[1:0]; the line address is inst_read_addr with bits [1:0] forced to 0.
REQ-016 SHALL split the address into tag = addr[ADDR_WIDTH-1:INDEX_BITS+2] and index = addr[INDEX_BITS+1:2].
REQ-017 On a hit accepted at cycle T, SHALL enter RESPOND and assert inst_read_done with the line data at T+1.
REQ-018 On a miss accepted at T, SHALL enter REFILL and drive mem_a = line address + k at cycle T+1+k, for k = 0..3.
REQ-019 SHALL capture mem_din at T+2+k into byte k of the word (little-endian).
REQ-020 At T+5 SHALL write the tag, data and valid bit, and enter RESPOND.
REQ-021 SHALL assert inst_read_done at T+6 for a miss; total miss latency is 6 cycles.
REQ-022 SHALL return from RESPOND to IDLE unconditionally after one cycle; inst_read_done SHALL be high only in RESPOND.
REQ-023 SHALL ignore inst_read_valid in REFILL and RESPOND; it SHALL NOT be queued.
REQ-024 inst_read_data SHALL hold its last value while inst_read_done is low.
REQ-025 mem_a SHALL hold its last value outside REFILL.
REQ-026 inst_cache_flush in IDLE or RESPOND SHALL clear all valid bits at the next edge; a pending RESPOND pulse SHALL still complete.
REQ-027 inst_cache_flush during REFILL SHALL abort the refill: no line write, no done, return to IDLE, all valid bits cleared.
REQ-028 inst_cache_flush SHALL take priority over a simultaneous inst_read_valid in IDLE; that request SHALL be dropped.
REQ-029 With rdy=0, a memory byte arriving that cycle SHALL be recaptured: the refill counter does not advance; memory is held stable by the system.

Reset
REQ-030 rst_n low SHALL immediately set state to IDLE, clear all valid bits and the refill counter, and drive inst_read_done=0, inst_read_data=0, mem_a=0.
REQ-031 Reset asserted mid-refill SHALL discard the partial line; no done pulse SHALL follow.
REQ-032 Tag and data arrays SHALL need no reset; only the valid bits are reset.

Structure
REQ-033 A shared package icache_pkg SHALL hold the state encoding (IDLE=0, REFILL=1, RESPOND=2) and the default widths.
REQ-034 The tag/data/valid storage SHALL be a sub-module icache_line_store with one read port and one write port; the FSM stays in inst_cache.

Verification
REQ-035 Cold miss: request 0x0000_1000; memory bytes 13,00,00,00 -> mem_a 0x1000..0x1003 at T+1..T+4, done at T+6, data 0x0000_0013.
REQ-036 Hit: repeat 0x0000_1000 after REQ-035 -> done at T+1, data 0x0000_0013, mem_a unchanged.
REQ-037 Conflict: request 0x0000_1100 (same index, new tag) -> miss; then 0x1000 misses again.
REQ-038 Flush at T+3 of a miss to 0x2000 -> no done; state IDLE at T+4; next 0x1000 request misses.
REQ-039 rdy low for 3 cycles at T+2 of a miss -> done delayed 3 cycles, data correct.
REQ-040 rst_n low at T+2 of a miss -> outputs zero immediately; no done; next request to the same address misses.
